// File: rtl/life_col4.sv
// One 4-cell column of a B3/S23 Game of Life board with cell write and column scan-load.
// Optional LIFE_COL4_POPCOUNT_EN adds a pop_count output (live cells in the column).
module life_col4 #(
    parameter int unsigned GEN_DIV = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] w_col,
    input  logic [3:0] e_col,
    input  logic       n,
    input  logic       s,
    input  logic       nw,
    input  logic       ne,
    input  logic       sw,
    input  logic       se,
    input  logic       write_enb,
    input  logic       val,
    input  logic [1:0] row,
    input  logic       enable,
    input  logic       scan,
    input  logic [3:0] scan_val,
    output logic [3:0] alive_col
`ifdef LIFE_COL4_POPCOUNT_EN
    ,
    output logic [2:0] pop_count
`endif
);

    if (GEN_DIV < 1 || GEN_DIV > 15) begin : g_bad_gen_div
        $error("life_col4: GEN_DIV must be in 1..15");
    end

    localparam logic [3:0] GenLast = 4'(GEN_DIV - 1);

    logic [3:0] alive_q, alive_d;
    logic [3:0] gen_cnt_q, gen_cnt_d;

    // Neighbour vectors aligned so bit i is the neighbour of cell i in that direction.
    logic [3:0] nb_above, nb_below;
    logic [3:0] nb_up_w, nb_up_e, nb_dn_w, nb_dn_e;

    assign nb_above = {alive_q[2:0], n};
    assign nb_below = {s, alive_q[3:1]};
    assign nb_up_w  = {w_col[2:0], nw};
    assign nb_up_e  = {e_col[2:0], ne};
    assign nb_dn_w  = {sw, w_col[3:1]};
    assign nb_dn_e  = {se, e_col[3:1]};

    logic [3:0] nb_cnt [4];
    logic [3:0] life_next;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            nb_cnt[i] = {3'b000, nb_above[i]} + {3'b000, nb_below[i]}
                      + {3'b000, w_col[i]}    + {3'b000, e_col[i]}
                      + {3'b000, nb_up_w[i]}  + {3'b000, nb_up_e[i]}
                      + {3'b000, nb_dn_w[i]}  + {3'b000, nb_dn_e[i]};
            life_next[i] = (nb_cnt[i] == 4'd3) | (alive_q[i] & (nb_cnt[i] == 4'd2));
        end
    end

    // Scan and write both stall the divider so a load never shifts the generation phase.
    logic gen_tick, gen_commit;

    assign gen_tick   = enable & ~scan & ~write_enb;
    assign gen_commit = gen_tick & (gen_cnt_q == GenLast);

    always_comb begin
        alive_d   = alive_q;
        gen_cnt_d = gen_cnt_q;
        if (scan) begin
            alive_d = scan_val;
        end else if (write_enb) begin
            alive_d[row] = val;
        end else if (gen_tick) begin
            if (gen_commit) begin
                alive_d   = life_next;
                gen_cnt_d = 4'd0;
            end else begin
                gen_cnt_d = gen_cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alive_q   <= 4'b0000;
            gen_cnt_q <= 4'd0;
        end else begin
            alive_q   <= alive_d;
            gen_cnt_q <= gen_cnt_d;
        end
    end

    assign alive_col = alive_q;

`ifdef LIFE_COL4_POPCOUNT_EN
    always_comb begin
        pop_count = 3'd0;
        for (int i = 0; i < 4; i++) begin
            pop_count = pop_count + {2'b00, alive_q[i]};
        end
    end
`endif

endmodule

// File: tb/tb_life_col4.sv
// Bench for life_col4: directed vector table, reset/freeze sequences, then random stimulus
// checked against a grid-based Game of Life model.
module tb_life_col4;

    localparam int GEN_DIV = 2;

    logic       clk;
    logic       reset;
    logic [3:0] w_col, e_col;
    logic       n, s, nw, ne, sw, se;
    logic       write_enb, val;
    logic [1:0] row;
    logic       enable, scan;
    logic [3:0] scan_val;
    logic [3:0] alive_col;
`ifdef LIFE_COL4_POPCOUNT_EN
    logic [2:0] pop_count;
`endif

    life_col4 #(.GEN_DIV(GEN_DIV)) dut (
        .clk       (clk),
        .reset     (reset),
        .w_col     (w_col),
        .e_col     (e_col),
        .n         (n),
        .s         (s),
        .nw        (nw),
        .ne        (ne),
        .sw        (sw),
        .se        (se),
        .write_enb (write_enb),
        .val       (val),
        .row       (row),
        .enable    (enable),
        .scan      (scan),
        .scan_val  (scan_val),
        .alive_col (alive_col)
`ifdef LIFE_COL4_POPCOUNT_EN
        ,
        .pop_count (pop_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // edges = {n, s, nw, ne, sw, se}
    typedef struct {
        string      name;
        logic       scn;
        logic [3:0] sv;
        logic       we;
        logic       v;
        logic [1:0] r;
        logic       en;
        logic [3:0] w;
        logic [3:0] e;
        logic [5:0] edges;
        logic [3:0] exp;
    } vec_t;

    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;

    logic [3:0] mdl_alive;
    int         mdl_cnt;

    function automatic vec_t mk(string nm, logic scn_i, logic [3:0] sv_i, logic we_i,
                                logic v_i, logic [1:0] r_i, logic en_i, logic [3:0] w_i,
                                logic [3:0] e_i, logic [5:0] edges_i, logic [3:0] exp_i);
        vec_t t;
        t.name = nm; t.scn = scn_i; t.sv = sv_i; t.we = we_i; t.v = v_i; t.r = r_i;
        t.en = en_i; t.w = w_i; t.e = e_i; t.edges = edges_i; t.exp = exp_i;
        return t;
    endfunction

    function automatic void check(string nm, logic [3:0] act, logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
`ifdef LIFE_COL4_POPCOUNT_EN
        checks++;
        if (pop_count !== 3'($countones(exp))) begin
            errors++;
            $display("FAIL %s pop_count: got %0d expected %0d", nm, pop_count,
                     $countones(exp));
        end
`endif
    endfunction

    // Reference: lay the 6x3 neighbourhood out as a grid and count the 3x3 window.
    function automatic logic [3:0] life_ref(logic [3:0] c, logic [3:0] w, logic [3:0] e,
                                            logic [5:0] edges);
        bit grid [6][3];
        logic [3:0] nxt;
        grid[0][0] = edges[3]; grid[0][1] = edges[5]; grid[0][2] = edges[2];
        grid[5][0] = edges[1]; grid[5][1] = edges[4]; grid[5][2] = edges[0];
        for (int r = 0; r < 4; r++) begin
            grid[r+1][0] = w[r]; grid[r+1][1] = c[r]; grid[r+1][2] = e[r];
        end
        for (int r = 0; r < 4; r++) begin
            int cnt = 0;
            for (int gr = r; gr < r + 3; gr++)
                for (int gc = 0; gc < 3; gc++)
                    cnt += int'(grid[gr][gc]);
            cnt -= int'(c[r]);
            nxt[r] = (cnt == 3) || (c[r] && cnt == 2);
        end
        return nxt;
    endfunction

    task automatic drive(vec_t t);
        scan = t.scn; scan_val = t.sv; write_enb = t.we; val = t.v; row = t.r;
        enable = t.en; w_col = t.w; e_col = t.e;
        {n, s, nw, ne, sw, se} = t.edges;
    endtask

    // Apply one edge, advance the model, compare.
    task automatic apply_model(vec_t t, string nm);
        logic [3:0] nxt;
        drive(t);
        nxt = mdl_alive;
        if (t.scn) nxt = t.sv;
        else if (t.we) nxt[t.r] = t.v;
        else if (t.en) begin
            if (mdl_cnt + 1 == GEN_DIV) begin
                nxt = life_ref(mdl_alive, t.w, t.e, t.edges);
                mdl_cnt = 0;
            end else mdl_cnt++;
        end
        mdl_alive = nxt;
        @(posedge clk); #1;
        check(nm, alive_col, mdl_alive);
    endtask

    initial begin
        vec_t t;
        reset = 1'b0;
        drive(mk("idle", 0, 4'h0, 0, 0, 2'd0, 0, 4'h0, 4'h0, 6'b0, 4'h0));
        #12;
        check("reset_state", alive_col, 4'b0000);
        @(negedge clk); reset = 1'b1;

        // Birth chain: n=1, w=e=0001
        for (int k = 0; k < 6; k++) begin
            logic [3:0] bc [6];
            bc = '{4'b0000, 4'b0001, 4'b0001, 4'b0011, 4'b0011, 4'b0010};
            tbl.push_back(mk($sformatf("birth%0d", k), 0, 4'h0, 0, 0, 2'd0, 1, 4'b0001,
                             4'b0001, 6'b100000, bc[k]));
        end
        tbl.push_back(mk("clear", 1, 4'b0000, 0, 0, 2'd0, 0, 4'h0, 4'h0, 6'b0, 4'b0000));
        tbl.push_back(mk("wr0", 0, 4'h0, 1, 1, 2'd0, 0, 4'h0, 4'h0, 6'b0, 4'b0001));
        tbl.push_back(mk("wr1", 0, 4'h0, 1, 1, 2'd1, 0, 4'h0, 4'h0, 6'b0, 4'b0011));
        tbl.push_back(mk("wr2", 0, 4'h0, 1, 1, 2'd2, 0, 4'h0, 4'h0, 6'b0, 4'b0111));
        tbl.push_back(mk("wr3", 0, 4'h0, 1, 1, 2'd3, 0, 4'h0, 4'h0, 6'b0, 4'b1111));
        for (int k = 0; k < 6; k++) begin
            logic [3:0] ev [6];
            ev = '{4'b1111, 4'b0110, 4'b0110, 4'b0000, 4'b0000, 4'b0000};
            tbl.push_back(mk($sformatf("evolve%0d", k), 0, 4'h0, 0, 0, 2'd0, 1, 4'h0, 4'h0,
                             6'b0, ev[k]));
        end
        tbl.push_back(mk("scan0", 1, 4'b0001, 0, 0, 2'd0, 0, 4'h0, 4'h0, 6'b0, 4'b0001));
        tbl.push_back(mk("scan1", 1, 4'b1000, 0, 0, 2'd0, 0, 4'h0, 4'h0, 6'b0, 4'b1000));
        tbl.push_back(mk("scan2", 1, 4'b0110, 0, 0, 2'd0, 0, 4'h0, 4'h0, 6'b0, 4'b0110));
        tbl.push_back(mk("scan3", 1, 4'b1111, 0, 0, 2'd0, 0, 4'h0, 4'h0, 6'b0, 4'b1111));
        tbl.push_back(mk("hold0", 0, 4'b0000, 0, 0, 2'd0, 0, 4'h0, 4'h0, 6'b0, 4'b1111));
        tbl.push_back(mk("hold1", 0, 4'b0000, 0, 0, 2'd0, 0, 4'h0, 4'h0, 6'b0, 4'b1111));
        // Divider to phase 1, then scan+write+enable must not advance it.
        tbl.push_back(mk("phase1", 0, 4'h0, 0, 0, 2'd0, 1, 4'h0, 4'h0, 6'b0, 4'b1111));
        tbl.push_back(mk("prio", 1, 4'b0110, 1, 1, 2'd0, 1, 4'h0, 4'h0, 6'b0, 4'b0110));
        tbl.push_back(mk("prio_commit", 0, 4'h0, 0, 0, 2'd0, 1, 4'h0, 4'h0, 6'b0, 4'b0000));

        #1;
        foreach (tbl[k]) begin
            drive(tbl[k]);
            @(posedge clk); #1;
            check(tbl[k].name, alive_col, tbl[k].exp);
        end

        // Asynchronous reset mid-cycle with a live pattern.
        drive(mk("ld", 1, 4'b1011, 0, 0, 2'd0, 0, 4'h0, 4'h0, 6'b0, 4'h0));
        @(posedge clk); #1;
        check("rst_preload", alive_col, 4'b1011);
        #2 reset = 1'b0;
        #1 check("rst_async", alive_col, 4'b0000);
        drive(mk("ld", 1, 4'b1111, 1, 1, 2'd2, 1, 4'hf, 4'hf, 6'h3f, 4'h0));
        @(posedge clk); #1;
        check("rst_hold", alive_col, 4'b0000);
        @(negedge clk);
        drive(mk("idle", 0, 4'h0, 0, 0, 2'd0, 0, 4'h0, 4'h0, 6'b0, 4'h0));
        reset = 1'b1;
        #1 check("rst_release", alive_col, 4'b0000);
        @(posedge clk); #1;
        mdl_alive = 4'b0000;
        mdl_cnt   = 0;
        check("rst_first_edge", alive_col, mdl_alive);

        // Freeze: divider parked at phase 1, births possible but enable low.
        apply_model(mk("", 1, 4'b0110, 0, 0, 2'd0, 0, 4'h0, 4'h0, 6'b0, 4'h0), "frz_load");
        apply_model(mk("", 0, 4'h0, 0, 0, 2'd0, 1, 4'h0, 4'h0, 6'b0, 4'h0), "frz_phase");
        for (int k = 0; k < 10; k++) begin
            apply_model(mk("", 0, 4'h0, 0, 0, 2'd0, 0, 4'b1011, 4'b1101, 6'b110011, 4'h0),
                        $sformatf("freeze%0d", k));
            check($sformatf("freeze_const%0d", k), alive_col, 4'b0110);
        end
        apply_model(mk("", 0, 4'h0, 0, 0, 2'd0, 1, 4'b1011, 4'b1101, 6'b110011, 4'h0),
                    "frz_resume");

        // Random traffic against the model.
        for (int k = 0; k < 400; k++) begin
            t = mk("", ($urandom_range(0, 15) == 0), 4'($urandom), ($urandom_range(0, 7) == 0),
                   1'($urandom), 2'($urandom), ($urandom_range(0, 3) != 0), 4'($urandom),
                   4'($urandom), 6'($urandom), 4'h0);
            apply_model(t, $sformatf("rand%0d", k));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
